regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scheduler for the 32x32 register file. It shares the file's single write port (we3/a3/wd3) between two producers: port 0, the main ALU/load write-back, and port 1, the long-latency unit write-back. It grants the two producers round-robin and registers the winning write for one cycle. It also keeps a per-register busy scoreboard so issue logic can stall on pending results.

---
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter for the 32x32 register file.
// Two producers (port 0 = ALU/load, port 1 = long-latency unit) share the single
// write port we3/a3/wd3. The winning write is registered for one cycle. A
// per-register busy scoreboard tracks pending results for issue stalls.
// Optional feature macro: WB_ARB_FWD_EN adds read-port bypass of the output stage.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0_valid,
  output logic                     p0_ready,
  input  logic [ADDR_W-1:0]        p0_addr,
  input  logic [DATA_W-1:0]        p0_data,
  input  logic                     p1_valid,
  output logic                     p1_ready,
  input  logic [ADDR_W-1:0]        p1_addr,
  input  logic [DATA_W-1:0]        p1_data,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
`ifdef WB_ARB_FWD_EN
  input  logic [ADDR_W-1:0]        a1,
  input  logic [ADDR_W-1:0]        a2,
  input  logic [DATA_W-1:0]        rd1_raw,
  input  logic [DATA_W-1:0]        rd2_raw,
  output logic [DATA_W-1:0]        rd1,
  output logic [DATA_W-1:0]        rd2,
`endif
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     we3,
  output logic [ADDR_W-1:0]        a3,
  output logic [DATA_W-1:0]        wd3
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic              last;
  logic              grant0;
  logic              grant1;
  logic              xfer0;
  logic              xfer1;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   busy_nxt;

  // Round-robin grant: on a tie the port not granted last wins
  always_comb begin
    grant0 = p0_valid && (!p1_valid || last);
    grant1 = p1_valid && (!p0_valid || !last);
  end

  // Readies are suppressed while reset is held
  assign p0_ready = grant0 && !reset;
  assign p1_ready = grant1 && !reset;

  assign xfer0    = p0_valid && p0_ready;
  assign xfer1    = p1_valid && p1_ready;
  assign xfer     = xfer0 || xfer1;
  assign win_addr = xfer1 ? p1_addr : p0_addr;
  assign win_data = xfer1 ? p1_data : p0_data;

  // Scoreboard next state: clear the accepted write, then apply a reservation
  always_comb begin
    busy_nxt = busy;
    if (xfer) begin
      busy_nxt[win_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Arbitration pointer, output stage and scoreboard registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
      we3  <= 1'b0;
      a3   <= '0;
      wd3  <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (xfer) begin
        last <= xfer1;
        we3  <= (win_addr != '0);
        a3   <= win_addr;
        wd3  <= win_data;
      end else begin
        we3  <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_FWD_EN
  // Bypass the write held in the output stage to the read ports
  always_comb begin
    rd1 = (we3 && (a1 == a3)) ? wd3 : rd1_raw;
    rd2 = (we3 && (a2 == a3)) ? wd3 : rd2_raw;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
// Honours WB_ARB_FWD_EN to exercise the read-port bypass when it is built in.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 2**ADDR_W;

  logic              clk;
  logic              reset;
  logic              p0_valid;
  logic              p0_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data;
  logic              p1_valid;
  logic              p1_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [NREG-1:0]   busy;
  logic              we3;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
`ifdef WB_ARB_FWD_EN
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
`endif

  int vectors;
  int miscompares;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_addr   (p0_addr),
    .p0_data   (p0_data),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_addr   (p1_addr),
    .p1_data   (p1_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
`ifdef WB_ARB_FWD_EN
    .a1        (a1),
    .a2        (a2),
    .rd1_raw   (rd1_raw),
    .rd2_raw   (rd2_raw),
    .rd1       (rd1),
    .rd2       (rd2),
`endif
    .busy      (busy),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare an observed value against its expectation
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    p0_valid    = 1'b0;
    p0_addr     = '0;
    p0_data     = '0;
    p1_valid    = 1'b0;
    p1_addr     = '0;
    p1_data     = '0;
    rsv_valid   = 1'b0;
    rsv_addr    = '0;
`ifdef WB_ARB_FWD_EN
    a1          = '0;
    a2          = '0;
    rd1_raw     = '0;
    rd2_raw     = '0;
`endif

    // Reset state, readies blocked while reset is held
    tick();
    tick();
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    #1;
    chk("rst_we3",   64'(we3),      64'(1'b0));
    chk("rst_a3",    64'(a3),       64'(5'd0));
    chk("rst_wd3",   64'(wd3),      64'(32'h0));
    chk("rst_busy",  64'(busy),     64'(32'h0));
    chk("rst_rdy0",  64'(p0_ready), 64'(1'b0));
    chk("rst_rdy1",  64'(p1_ready), 64'(1'b0));
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Contention: both valid, p0 wins first tie after reset
    p0_valid = 1'b1; p0_addr = 5'd1; p0_data = 32'h1111_0001;
    p1_valid = 1'b1; p1_addr = 5'd3; p1_data = 32'h3333_0003;
    #1;
    chk("cont1_rdy0", 64'(p0_ready), 64'(1'b1));
    chk("cont1_rdy1", 64'(p1_ready), 64'(1'b0));
    tick();
    chk("cont1_a3",  64'(a3),  64'(5'd1));
    chk("cont1_wd3", 64'(wd3), 64'(32'h1111_0001));
    p0_addr = 5'd2; p0_data = 32'h2222_0002;
    #1;
    chk("cont2_rdy0", 64'(p0_ready), 64'(1'b0));
    chk("cont2_rdy1", 64'(p1_ready), 64'(1'b1));
    tick();
    chk("cont2_a3",  64'(a3),  64'(5'd3));
    chk("cont2_wd3", 64'(wd3), 64'(32'h3333_0003));
    p1_addr = 5'd4; p1_data = 32'h4444_0004;
    #1;
    chk("cont3_rdy0", 64'(p0_ready), 64'(1'b1));
    tick();
    chk("cont3_a3",  64'(a3),  64'(5'd2));
    p0_addr = 5'd6; p0_data = 32'h6666_0006;
    #1;
    chk("cont4_rdy1", 64'(p1_ready), 64'(1'b1));
    tick();
    chk("cont4_a3",  64'(a3),  64'(5'd4));
    chk("cont4_we3", 64'(we3), 64'(1'b1));
    p1_valid = 1'b0;
    #1;
    chk("cont5_rdy0", 64'(p0_ready), 64'(1'b1));
    tick();
    chk("cont5_a3",  64'(a3),  64'(5'd6));
    p0_valid = 1'b0;
    tick();
    chk("idle_we3", 64'(we3), 64'(1'b0));
    chk("idle_a3",  64'(a3),  64'(5'd6));
    chk("idle_wd3", 64'(wd3), 64'(32'h6666_0006));

    // Single port: back-to-back grant to p0 with p1 idle
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hDEAD_BEEF;
    #1;
    chk("single_rdy0", 64'(p0_ready), 64'(1'b1));
    tick();
    p0_valid = 1'b0;
    chk("single_we3", 64'(we3), 64'(1'b1));
    chk("single_a3",  64'(a3),  64'(5'd5));
    chk("single_wd3", 64'(wd3), 64'(32'hDEAD_BEEF));

    // x0 drop on port 1
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 32'h0000_1234;
    #1;
    chk("x0_rdy1", 64'(p1_ready), 64'(1'b1));
    tick();
    p1_valid = 1'b0;
    chk("x0_we3",  64'(we3),  64'(1'b0));
    chk("x0_busy", 64'(busy), 64'(32'h0));

    // Scoreboard: reserve r7, reserve of r0 is ignored
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    chk("sb_set7", 64'(busy), 64'(32'h0000_0080));
    rsv_addr = 5'd0;
    tick();
    chk("sb_rsv0", 64'(busy), 64'(32'h0000_0080));
    // Write r7 and re-reserve r7 in the same cycle: set wins
    rsv_addr = 5'd7;
    p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'h7777_0007;
    tick();
    rsv_valid = 1'b0;
    chk("sb_setwin", 64'(busy), 64'(32'h0000_0080));
    chk("sb_we3",    64'(we3),  64'(1'b1));
    // Later write to r7 alone clears it
    p0_data = 32'h7777_0008;
    tick();
    p0_valid = 1'b0;
    chk("sb_clr7", 64'(busy), 64'(32'h0));
    chk("sb_wd3",  64'(wd3),  64'(32'h7777_0008));

`ifdef WB_ARB_FWD_EN
    // Forwarding of the output stage to both read ports
    a1 = 5'd9; rd1_raw = 32'h0;
    a2 = 5'd3; rd2_raw = 32'h0000_0055;
    p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'hA5A5_A5A5;
    tick();
    p1_valid = 1'b0;
    chk("fwd_rd1",    64'(rd1), 64'(32'hA5A5_A5A5));
    chk("fwd_rd2raw", 64'(rd2), 64'(32'h0000_0055));
    a2 = 5'd9;
    #1;
    chk("fwd_rd2", 64'(rd2), 64'(32'hA5A5_A5A5));
    tick();
    chk("fwd_rd1_after", 64'(rd1), 64'(32'h0));
`endif

    // Reset mid-operation discards the held write and the scoreboard
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    p0_valid = 1'b1; p0_addr = 5'd9; p0_data = 32'hCAFE_F00D;
    tick();
    rsv_valid = 1'b0;
    chk("mid_we3_pre",  64'(we3),  64'(1'b1));
    chk("mid_busy_pre", 64'(busy), 64'(32'h0000_1000));
    p1_valid = 1'b1; p1_addr = 5'd10; p1_data = 32'h1010_1010;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_we3",  64'(we3),  64'(1'b0));
    chk("mid_a3",   64'(a3),   64'(5'd0));
    chk("mid_wd3",  64'(wd3),  64'(32'h0));
    chk("mid_busy", 64'(busy), 64'(32'h0));
    tick();
    chk("mid_rdy0", 64'(p0_ready), 64'(1'b0));
    chk("mid_rdy1", 64'(p1_ready), 64'(1'b0));
    reset = 1'b0;
    p1_valid = 1'b0;
    #1;
    chk("post_rdy0", 64'(p0_ready), 64'(1'b1));
    tick();
    p0_valid = 1'b0;
    chk("post_a3",  64'(a3),  64'(5'd9));
    chk("post_wd3", 64'(wd3), 64'(32'hCAFE_F00D));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
